sc_mul_err_monitor: RTL and testbench

- Downstream consumer of the SC multiplier tops. Samples each operand pair and the SC product, computes the exact binary product, and accumulates error statistics in registers.
- Used in simulation benches and in on-FPGA accuracy characterisation of SC multipliers.
- Pipelined at 2 stages. Accepts one sample per cycle.

---
 rtl/sc_mon_pkg.sv | 25 ++
 rtl/sc_sat_accum.sv | 41 ++++
 rtl/sc_mul_err_monitor.sv | 129 ++++++++++++
 tb/tb_sc_mul_err_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_mon_pkg.sv
// Shared widths and saturation helper for the SC multiplier error monitor.
package sc_mon_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_RESULT_SHIFT = 0;
    localparam int unsigned DEF_COUNT_WIDTH  = 20;
    localparam int unsigned DEF_SUM_WIDTH    = 32;
    localparam int unsigned PROD_WIDTH       = 2 * DEF_DATA_WIDTH;

    // Widest accumulator the saturation helper supports.
    localparam int unsigned SAT_W = 64;

    // Saturating add decision: true when acc + addend would exceed all_ones,
    // i.e. the accumulator must clamp and flag overflow.
    function automatic logic sat_add_ovf(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] addend,
        input logic [SAT_W-1:0] all_ones
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, acc} + {1'b0, addend};
        return (sum > {1'b0, all_ones});
    endfunction

endpackage

// File: rtl/sc_sat_accum.sv
// Saturating accumulator with sticky saturation flag.
module sc_sat_accum
    import sc_mon_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] value,
    output logic             sat
);

    localparam logic [SAT_W-1:0] ALL_ONES = SAT_W'({WIDTH{1'b1}});

    logic [WIDTH-1:0] r_value;
    logic             r_sat;
    logic             w_ovf;

    // Detect whether this update would pass all-ones.
    always_comb begin
        w_ovf = sat_add_ovf(SAT_W'(r_value), SAT_W'(addend), ALL_ONES);
    end

    // Accumulate with clamp; rst and clear both zero the value and flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_value <= '0;
            r_sat   <= 1'b0;
        end else if (en) begin
            r_value <= w_ovf ? {WIDTH{1'b1}} : r_value + addend;
            r_sat   <= r_sat | w_ovf;
        end
    end

    assign value = r_value;
    assign sat   = r_sat;

endmodule

// File: rtl/sc_mul_err_monitor.sv
// Two-stage accuracy monitor: exact product vs. SC product, error statistics.
module sc_mul_err_monitor
    import sc_mon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned RESULT_SHIFT = DEF_RESULT_SHIFT,
    parameter int unsigned COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int unsigned SUM_WIDTH    = DEF_SUM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   io_inputs_a,
    input  logic [DATA_WIDTH-1:0]   io_inputs_b,
    input  logic [2*DATA_WIDTH-1:0] mul_result,
    output logic                    last_valid,
    output logic [2*DATA_WIDTH-1:0] last_err,
    output logic [COUNT_WIDTH-1:0]  sample_count,
    output logic [COUNT_WIDTH-1:0]  exact_count,
    output logic [SUM_WIDTH-1:0]    err_sum,
    output logic [2*DATA_WIDTH-1:0] max_err,
    output logic [DATA_WIDTH-1:0]   max_err_a,
    output logic [DATA_WIDTH-1:0]   max_err_b,
    output logic                    overflow
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic                  r_v1;
    logic [PW-1:0]         r_exact;
    logic [PW-1:0]         r_aligned;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;

    logic                  r_last_valid;
    logic [PW-1:0]         r_last_err;
    logic [PW-1:0]         r_max_err;
    logic [DATA_WIDTH-1:0] r_max_a;
    logic [DATA_WIDTH-1:0] r_max_b;

    logic [PW-1:0]         w_diff;
    logic                  w_sat_samp;
    logic                  w_sat_exact;
    logic                  w_sat_sum;

    // Stage 1: full-width exact product and scale-aligned SC product.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_v1      <= 1'b0;
            r_exact   <= '0;
            r_aligned <= '0;
            r_a       <= '0;
            r_b       <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_exact   <= PW'(io_inputs_a) * PW'(io_inputs_b);
                r_aligned <= PW'(mul_result << RESULT_SHIFT);
                r_a       <= io_inputs_a;
                r_b       <= io_inputs_b;
            end
        end
    end

    // Absolute error of the stage-1 sample.
    always_comb begin
        w_diff = (r_exact >= r_aligned) ? (r_exact - r_aligned) : (r_aligned - r_exact);
    end

    // Stage 2: latest error and max tracking (ties keep the earlier sample).
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_last_valid <= 1'b0;
            r_last_err   <= '0;
            r_max_err    <= '0;
            r_max_a      <= '0;
            r_max_b      <= '0;
        end else begin
            r_last_valid <= r_v1;
            if (r_v1) begin
                r_last_err <= w_diff;
                if (w_diff > r_max_err) begin
                    r_max_err <= w_diff;
                    r_max_a   <= r_a;
                    r_max_b   <= r_b;
                end
            end
        end
    end

    sc_sat_accum #(.WIDTH(COUNT_WIDTH)) u_samp_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .en     (r_v1),
        .addend (COUNT_WIDTH'(1)),
        .value  (sample_count),
        .sat    (w_sat_samp)
    );

    sc_sat_accum #(.WIDTH(COUNT_WIDTH)) u_exact_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .en     (r_v1 && (w_diff == '0)),
        .addend (COUNT_WIDTH'(1)),
        .value  (exact_count),
        .sat    (w_sat_exact)
    );

    sc_sat_accum #(.WIDTH(SUM_WIDTH)) u_err_sum (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .en     (r_v1),
        .addend (SUM_WIDTH'(w_diff)),
        .value  (err_sum),
        .sat    (w_sat_sum)
    );

    assign last_valid = r_last_valid;
    assign last_err   = r_last_err;
    assign max_err    = r_max_err;
    assign max_err_a  = r_max_a;
    assign max_err_b  = r_max_b;
    assign overflow   = w_sat_samp | w_sat_exact | w_sat_sum;

endmodule

// File: tb/tb_sc_mul_err_monitor.sv
// Bench for sc_mul_err_monitor: vector table, corner sequences, random vs. model.
module tb_sc_mul_err_monitor;
    import sc_mon_pkg::*;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] m;

    // Per-DUT outputs: 0 = defaults, 1 = RESULT_SHIFT 1, 2 = COUNT_WIDTH 4.
    logic        lv [3];
    logic [15:0] le [3];
    logic [15:0] mx [3];
    logic [7:0]  ma [3];
    logic [7:0]  mb [3];
    logic [31:0] es [3];
    logic        ov [3];
    logic [19:0] sc0, sc1, ec0, ec1;
    logic [3:0]  sc2, ec2;

    int n_chk  = 0;
    int n_fail = 0;

    sc_mul_err_monitor u_d0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .io_inputs_a(a), .io_inputs_b(b), .mul_result(m),
        .last_valid(lv[0]), .last_err(le[0]), .sample_count(sc0), .exact_count(ec0),
        .err_sum(es[0]), .max_err(mx[0]), .max_err_a(ma[0]), .max_err_b(mb[0]),
        .overflow(ov[0])
    );

    sc_mul_err_monitor #(.RESULT_SHIFT(1)) u_d1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .io_inputs_a(a), .io_inputs_b(b), .mul_result(m),
        .last_valid(lv[1]), .last_err(le[1]), .sample_count(sc1), .exact_count(ec1),
        .err_sum(es[1]), .max_err(mx[1]), .max_err_a(ma[1]), .max_err_b(mb[1]),
        .overflow(ov[1])
    );

    sc_mul_err_monitor #(.COUNT_WIDTH(4)) u_d2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .io_inputs_a(a), .io_inputs_b(b), .mul_result(m),
        .last_valid(lv[2]), .last_err(le[2]), .sample_count(sc2), .exact_count(ec2),
        .err_sum(es[2]), .max_err(mx[2]), .max_err_a(ma[2]), .max_err_b(mb[2]),
        .overflow(ov[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: one pending sample, statistics per DUT.
    int     shf  [3] = '{0, 1, 0};
    longint cmax [3] = '{longint'(20'hFFFFF), longint'(20'hFFFFF), 15};
    localparam longint SMAX = 64'hFFFF_FFFF;

    bit     p_v;
    longint p_a, p_b, p_m;
    bit     m_lv [3];
    bit     m_ov [3];
    longint m_le [3], m_sc [3], m_ec [3], m_es [3], m_mx [3], m_ma [3], m_mb [3];

    task automatic chk(input int k, input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL d%0d.%s at %0t: got %0d expected %0d", k, nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_lv[k] = 0; m_ov[k] = 0; m_le[k] = 0; m_sc[k] = 0; m_ec[k] = 0;
            m_es[k] = 0; m_mx[k] = 0; m_ma[k] = 0; m_mb[k] = 0;
        end
        p_v = 0;
    endtask

    // One clock edge of the intended behaviour, using the inputs seen at that edge.
    task automatic model_step();
        longint ex, al, d;
        if (rst || clear) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            m_lv[k] = p_v;
            if (p_v) begin
                ex = p_a * p_b;
                al = (p_m << shf[k]) & 64'hFFFF;
                d  = (ex > al) ? ex - al : al - ex;
                m_le[k] = d;
                if (m_sc[k] == cmax[k]) m_ov[k] = 1; else m_sc[k]++;
                if (d == 0) begin
                    if (m_ec[k] == cmax[k]) m_ov[k] = 1; else m_ec[k]++;
                end
                if (m_es[k] + d > SMAX) begin
                    m_es[k] = SMAX; m_ov[k] = 1;
                end else begin
                    m_es[k] += d;
                end
                if (d > m_mx[k]) begin
                    m_mx[k] = d; m_ma[k] = p_a; m_mb[k] = p_b;
                end
            end
        end
        p_v = in_valid;
        p_a = longint'(a);
        p_b = longint'(b);
        p_m = longint'(m);
    endtask

    task automatic check_all();
        longint scv, ecv;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin scv = longint'(sc0); ecv = longint'(ec0); end
                1:       begin scv = longint'(sc1); ecv = longint'(ec1); end
                default: begin scv = longint'(sc2); ecv = longint'(ec2); end
            endcase
            chk(k, "last_valid",   longint'(lv[k]), longint'(m_lv[k]));
            chk(k, "last_err",     longint'(le[k]), m_le[k]);
            chk(k, "sample_count", scv,             m_sc[k]);
            chk(k, "exact_count",  ecv,             m_ec[k]);
            chk(k, "err_sum",      longint'(es[k]), m_es[k]);
            chk(k, "max_err",      longint'(mx[k]), m_mx[k]);
            chk(k, "max_err_a",    longint'(ma[k]), m_ma[k]);
            chk(k, "max_err_b",    longint'(mb[k]), m_mb[k]);
            chk(k, "overflow",     longint'(ov[k]), longint'(m_ov[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit r, input bit c, input bit v,
                         input int ia, input int ib, input int im);
        rst = r; clear = c; in_valid = v;
        a = 8'(ia); b = 8'(ib); m = 16'(im);
        cycle();
    endtask

    typedef struct {
        bit r; bit c; bit v;
        int a; int b; int m;
        bit lv; int le; int sc; int ec; int es; int mx;
    } vec_t;

    vec_t vt [8];

    initial begin
        rst = 1; clear = 0; in_valid = 0; a = 0; b = 0; m = 0;
        model_reset();

        // Exact hit, then under- and over-estimate back-to-back on the default DUT.
        vt[0] = '{1,0,0,  0, 0,  0, 0,0,0,0, 0,0};
        vt[1] = '{1,0,0,  0, 0,  0, 0,0,0,0, 0,0};
        vt[2] = '{0,0,1, 11,12,132, 0,0,0,0, 0,0};
        vt[3] = '{0,0,0,  0, 0,  0, 1,0,1,1, 0,0};
        vt[4] = '{0,0,1, 11,12,130, 0,0,1,1, 0,0};
        vt[5] = '{0,0,1, 14,15,218, 1,2,2,1, 2,2};
        vt[6] = '{0,0,0,  0, 0,  0, 1,8,3,1,10,8};
        vt[7] = '{0,0,0,  0, 0,  0, 0,8,3,1,10,8};
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].r, vt[i].c, vt[i].v, vt[i].a, vt[i].b, vt[i].m);
            chk(0, "tbl_last_valid", longint'(lv[0]), longint'(vt[i].lv));
            chk(0, "tbl_last_err",   longint'(le[0]), longint'(vt[i].le));
            chk(0, "tbl_sample_cnt", longint'(sc0),   longint'(vt[i].sc));
            chk(0, "tbl_exact_cnt",  longint'(ec0),   longint'(vt[i].ec));
            chk(0, "tbl_err_sum",    longint'(es[0]), longint'(vt[i].es));
            chk(0, "tbl_max_err",    longint'(mx[0]), longint'(vt[i].mx));
        end
        chk(0, "tbl_max_err_a", longint'(ma[0]), 14);
        chk(0, "tbl_max_err_b", longint'(mb[0]), 15);

        // Shifted alignment and tie on max error (DUT 1).
        drive(1,0,0, 0,0,0);
        drive(0,0,1, 3,4,5);
        drive(0,0,1, 2,4,0);
        drive(0,0,1, 4,4,4);
        drive(0,0,0, 0,0,0);
        drive(0,0,0, 0,0,0);
        chk(1, "tie_max_err",   longint'(mx[1]), 8);
        chk(1, "tie_max_err_a", longint'(ma[1]), 2);
        chk(1, "tie_max_err_b", longint'(mb[1]), 4);
        chk(1, "tie_err_sum",   longint'(es[1]), 18);
        chk(1, "tie_last_err",  longint'(le[1]), 8);

        // Saturation of 4-bit counters (DUT 2), overflow sticky until clear.
        drive(1,0,0, 0,0,0);
        for (int i = 0; i < 17; i++) drive(0,0,1, 11,12,132);
        drive(0,0,0, 0,0,0);
        chk(2, "sat_sample_cnt", longint'(sc2),   15);
        chk(2, "sat_exact_cnt",  longint'(ec2),   15);
        chk(2, "sat_overflow",   longint'(ov[2]), 1);
        chk(0, "nosat_sample",   longint'(sc0),   17);
        for (int i = 0; i < 3; i++) drive(0,0,0, 0,0,0);
        chk(2, "sat_sticky",     longint'(ov[2]), 1);
        drive(0,1,0, 0,0,0);
        chk(2, "sat_cleared",    longint'(ov[2]), 0);
        chk(2, "sat_cnt_clr",    longint'(sc2),   0);

        // Clear colliding with an in-flight sample and a new one.
        drive(1,0,0, 0,0,0);
        drive(0,0,1, 11,12,127);
        drive(0,1,1, 2,3,6);
        chk(0, "clr_sample_cnt", longint'(sc0),   0);
        chk(0, "clr_err_sum",    longint'(es[0]), 0);
        chk(0, "clr_last_valid", longint'(lv[0]), 0);
        chk(0, "clr_max_err",    longint'(mx[0]), 0);
        drive(0,0,0, 0,0,0);
        drive(0,0,0, 0,0,0);
        chk(0, "clr_still_zero", longint'(sc0),   0);
        chk(0, "clr_no_pulse",   longint'(lv[0]), 0);

        // Reset in the middle of a continuous exact-hit stream.
        for (int k = 0; k < 12; k++) begin
            drive((k == 5), 0, 1, 11 + 3*k, 12 + 3*k, (11 + 3*k) * (12 + 3*k));
            if (k == 5) begin
                chk(0, "rst_sample_cnt", longint'(sc0),   0);
                chk(0, "rst_last_valid", longint'(lv[0]), 0);
                chk(0, "rst_last_err",   longint'(le[0]), 0);
            end
            if (k == 7) chk(0, "rst_resume_cnt", longint'(sc0), 1);
        end

        // Random traffic including full-scale operands, occasional clear/reset.
        for (int i = 0; i < 300; i++) begin
            int ia, ib, im;
            ia = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 255));
            ib = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) im = int'($urandom_range(0, 65535));
            else begin
                im = ia * ib + int'($urandom_range(0, 6)) - 3;
                if (im < 0) im = 0;
                if (im > 65535) im = 65535;
            end
            drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0), ia, ib, im);
        end
        drive(0,0,0, 0,0,0);
        drive(0,0,0, 0,0,0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
